logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 SHALL have parameter: width, default 32, operand/result bit width.
REQ-002 SHALL have port: clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req0_valid_i  input  1  requester 0 has an operation.
REQ-005 SHALL have port: req0_ready_o  output  1  requester 0 operation accepted this cycle.
REQ-006 SHALL have port: req0_A_i / req0_B_i  input  width each  requester 0 operands.
REQ-007 SHALL have port: req0_op_i  input  2  requester 0 logic_op (00 AND, 01 XOR, 10 OR, 11 zero).
REQ-008 SHALL have ports: req1_valid_i, req1_ready_o, req1_A_i, req1_B_i, req1_op_i with the same directions, widths and meanings for requester 1.
REQ-009 SHALL have port: rsp_valid_o  output  1  result register holds an unconsumed result.
REQ-010 SHALL have port: rsp_ready_i  input  1  consumer takes result this cycle.
REQ-011 SHALL have port: rsp_result_o  output  width  registered logic result.
REQ-012 SHALL have port: rsp_id_o  output  1  requester index (0/1) that produced rsp_result_o.

Function
REQ-013 SHALL define a transfer on any port as valid and ready both high at a rising edge.
REQ-014 SHALL define slot_free = !rsp_valid_o || rsp_ready_i (combinational).
REQ-015 SHALL grant at most one requester per cycle; readyN_o high only when slot_free and requester N is granted.
REQ-016 SHALL grant the only valid requester when exactly one is valid.
REQ-017 SHALL, when both are valid, grant the requester indicated by a 1-bit priority pointer.
REQ-018 SHALL set the pointer, on each accepted request, to the requester not granted; it is unchanged on cycles with no acceptance.
REQ-019 SHALL, on acceptance, load rsp_result_o with the logic result of the granted operands/op, load rsp_id_o with the grant index, and set rsp_valid_o -- latency exactly 1 cycle.
REQ-020 SHALL produce op 11 result of all zeros, still completing a normal response.
REQ-021 SHALL hold rsp_valid_o, rsp_result_o and rsp_id_o stable while rsp_valid_o && !rsp_ready_i.
REQ-022 SHALL clear rsp_valid_o when a response transfers and no request is accepted in the same cycle.
REQ-023 SHALL, when a response transfers and a request is accepted in the same cycle, load the new result with rsp_valid_o remaining high (throughput 1 op/cycle, no bubble).
REQ-024 SHALL not combinationally depend readyN_o on reqN_valid_i of the same requester other than through the grant rule; ready SHALL not depend on operand/op values.
REQ-025 SHALL require requesters to hold valid, operands and op stable until accepted; behaviour with non-compliant requesters is unspecified.
REQ-026 SHALL not drop, duplicate or reorder results: responses leave in acceptance order.

Reset
REQ-027 SHALL, while rst_i high (asynchronously), force rsp_valid_o=0, rsp_result_o=0, rsp_id_o=0, pointer=0 (requester 0 favoured).
REQ-028 SHALL drive req0_ready_o=0 and req1_ready_o=0 during reset.
REQ-029 SHALL discard any held response on reset mid-operation; no result is emitted after deassertion until a new acceptance.

Structure
REQ-030 SHALL place logic_op encodings (AND/XOR/OR/ZERO) and requester-index constants in the shared execute-stage package.
REQ-031 SHALL instantiate one Logic_Unit sub-module fed by a grant-selected operand/op mux; no duplicate logic datapath.

Verification
REQ-032 SHALL verify: req0 only, A=F0F0F0F0, B=0FF0FF00, op=00 -> next cycle rsp_valid=1, result=00F0F000, id=0.
REQ-033 SHALL verify: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; one response per cycle.
REQ-034 SHALL verify: rsp_ready=0 for 3 cycles with result held -> both readyN_o=0, rsp outputs unchanged; on rsp_ready=1 a pending request is accepted that same cycle.
REQ-035 SHALL verify: req1 op=11, A=B=FFFFFFFF -> result=00000000, id=1.
REQ-036 SHALL verify: rst_i asserted mid-cycle with rsp_valid=1 -> rsp_valid drops immediately, pointer=0, no stale result after release.
REQ-037 SHALL verify: random valid/ready stimulus 10k cycles against reference model -> every accepted request yields exactly one in-order response with correct result and id.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// ============================================================================
// Module   : logic_unit_arbiter_pkg
// Brief    : Shared execute-stage definitions: logic_op encodings, requester
//            indices and the two-requester grant selection helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_unit_arbiter_pkg;

   typedef enum logic [1:0] {
      LOGIC_OP_AND  = 2'b00,
      LOGIC_OP_XOR  = 2'b01,
      LOGIC_OP_OR   = 2'b10,
      LOGIC_OP_ZERO = 2'b11
   } logic_op_e;

   localparam int   c_num_req  = 2;
   localparam logic c_req0_id  = 1'b0;
   localparam logic c_req1_id  = 1'b1;
   localparam logic c_ptr_rst  = c_req0_id;

   // A lone valid requester always wins; the pointer only breaks ties.
   function automatic logic grant_select(input logic valid0,
                                         input logic valid1,
                                         input logic ptr);
      logic idx;
      if (valid0 && valid1) begin
         idx = ptr;
      end else if (valid1) begin
         idx = c_req1_id;
      end else begin
         idx = c_req0_id;
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/logic_unit_arbiter_logic_unit.sv
// ============================================================================
// Module   : logic_unit_arbiter_logic_unit
// Brief    : Combinational bitwise logic datapath (AND / XOR / OR / zero).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_arbiter_logic_unit
   import logic_unit_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [1:0]       i_op,
   output logic [WIDTH-1:0] o_result
);

   logic_op_e w_op;

   assign w_op = logic_op_e'(i_op);

   always_comb begin
      o_result = '0;
      case (w_op)
         LOGIC_OP_AND:  o_result = i_a & i_b;
         LOGIC_OP_XOR:  o_result = i_a ^ i_b;
         LOGIC_OP_OR:   o_result = i_a | i_b;
         LOGIC_OP_ZERO: o_result = '0;
         default:       o_result = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
// ============================================================================
// Module   : logic_unit_arbiter
// Brief    : Two-requester round-robin arbiter in front of a single logic
//            unit with a one-entry registered response slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_arbiter
   import logic_unit_arbiter_pkg::*;
#(
   parameter int width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,

   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [width-1:0] req0_A_i,
   input  logic [width-1:0] req0_B_i,
   input  logic [1:0]       req0_op_i,

   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [width-1:0] req1_A_i,
   input  logic [width-1:0] req1_B_i,
   input  logic [1:0]       req1_op_i,

   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [width-1:0] rsp_result_o,
   output logic             rsp_id_o
);

   logic             r_rsp_valid;
   logic [width-1:0] r_rsp_result;
   logic             r_rsp_id;
   logic             r_ptr;

   logic             w_slot_free;
   logic             w_any_valid;
   logic             w_grant;
   logic             w_accept;
   logic [width-1:0] w_mux_a;
   logic [width-1:0] w_mux_b;
   logic [1:0]       w_mux_op;
   logic [width-1:0] w_lu_result;

   assign w_slot_free = !r_rsp_valid || rsp_ready_i;
   assign w_any_valid = req0_valid_i || req1_valid_i;
   assign w_grant     = grant_select(req0_valid_i, req1_valid_i, r_ptr);

   // Reset gates acceptance so neither requester sees ready while rst_i is high.
   assign w_accept     = !rst_i && w_slot_free && w_any_valid;
   assign req0_ready_o = w_accept && (w_grant == c_req0_id);
   assign req1_ready_o = w_accept && (w_grant == c_req1_id);

   assign w_mux_a  = (w_grant == c_req1_id) ? req1_A_i  : req0_A_i;
   assign w_mux_b  = (w_grant == c_req1_id) ? req1_B_i  : req0_B_i;
   assign w_mux_op = (w_grant == c_req1_id) ? req1_op_i : req0_op_i;

   logic_unit_arbiter_logic_unit #(
      .WIDTH (width)
   ) u_logic_unit (
      .i_a      (w_mux_a),
      .i_b      (w_mux_b),
      .i_op     (w_mux_op),
      .o_result (w_lu_result)
   );

   // A new acceptance overwrites the slot even while the old result is
   // being consumed, giving back-to-back responses without a bubble.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_id     <= c_req0_id;
         r_ptr        <= c_ptr_rst;
      end else if (w_accept) begin
         r_rsp_valid  <= 1'b1;
         r_rsp_result <= w_lu_result;
         r_rsp_id     <= w_grant;
         r_ptr        <= ~w_grant;
      end else if (rsp_ready_i) begin
         r_rsp_valid  <= 1'b0;
      end
   end

   assign rsp_valid_o  = r_rsp_valid;
   assign rsp_result_o = r_rsp_result;
   assign rsp_id_o     = r_rsp_id;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
// ============================================================================
// Module   : tb_logic_unit_arbiter
// Brief    : Directed and random self-checking bench for logic_unit_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_arbiter;

   logic        clk;
   logic        rst_i;
   logic        req0_valid_i, req0_ready_o;
   logic [31:0] req0_A_i, req0_B_i;
   logic [1:0]  req0_op_i;
   logic        req1_valid_i, req1_ready_o;
   logic [31:0] req1_A_i, req1_B_i;
   logic [1:0]  req1_op_i;
   logic        rsp_valid_o, rsp_ready_i;
   logic [31:0] rsp_result_o;
   logic        rsp_id_o;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic_unit_arbiter #(.width(32)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .req0_valid_i (req0_valid_i),
      .req0_ready_o (req0_ready_o),
      .req0_A_i     (req0_A_i),
      .req0_B_i     (req0_B_i),
      .req0_op_i    (req0_op_i),
      .req1_valid_i (req1_valid_i),
      .req1_ready_o (req1_ready_o),
      .req1_A_i     (req1_A_i),
      .req1_B_i     (req1_B_i),
      .req1_op_i    (req1_op_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_result_o (rsp_result_o),
      .rsp_id_o     (rsp_id_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a ^ b;
         2'b10:   return a | b;
         default: return 32'h0;
      endcase
   endfunction

   logic [32:0] exp_q[$];
   logic [32:0] exp_rsp;
   logic        m_ptr, m_valid, m_slot, m_g, acc0, acc1, pend0, pend1;
   logic [31:0] a0, b0, a1, b1;
   logic [1:0]  op0, op1;

   initial begin
      rst_i = 1'b1;
      req0_valid_i = 0; req0_A_i = 0; req0_B_i = 0; req0_op_i = 0;
      req1_valid_i = 0; req1_A_i = 0; req1_B_i = 0; req1_op_i = 0;
      rsp_ready_i = 0;

      // Reset state, with both requesters asserting valid
      repeat (2) @(negedge clk);
      req0_valid_i = 1; req1_valid_i = 1;
      #1;
      chk("rst_valid",  rsp_valid_o,  0);
      chk("rst_result", rsp_result_o, 0);
      chk("rst_id",     rsp_id_o,     0);
      chk("rst_ready",  {req1_ready_o, req0_ready_o}, 2'b00);

      // Round-robin alternation from reset, one response per cycle
      @(negedge clk);
      rst_i = 0;
      req0_A_i = 32'hFFFF0000; req0_B_i = 32'h12345678; req0_op_i = 2'b00;
      req1_A_i = 32'hFFFFFFFF; req1_B_i = 32'h12345678; req1_op_i = 2'b01;
      rsp_ready_i = 1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("alt_ready", {req1_ready_o, req0_ready_o}, i[0] ? 2'b10 : 2'b01);
         @(negedge clk); #1;
         chk("alt_rsp", {rsp_valid_o, rsp_id_o, rsp_result_o},
             {1'b1, i[0], i[0] ? 32'hEDCBA987 : 32'h12340000});
      end
      req0_valid_i = 0; req1_valid_i = 0;
      #1;
      chk("idle_ready", {req1_ready_o, req0_ready_o}, 2'b00);
      @(negedge clk); #1;
      chk("drain_valid", rsp_valid_o, 0);

      // Single requester 0 AND
      req0_valid_i = 1; req0_A_i = 32'hF0F0F0F0; req0_B_i = 32'h0FF0FF00; req0_op_i = 2'b00;
      rsp_ready_i = 0;
      #1;
      chk("and_ready", {req1_ready_o, req0_ready_o}, 2'b01);
      @(negedge clk);
      req0_valid_i = 0;
      #1;
      chk("and_rsp", {rsp_valid_o, rsp_id_o, rsp_result_o}, {1'b1, 1'b0, 32'h00F0F000});

      // Backpressure: held result, no grants, then same-cycle accept on release
      req0_valid_i = 1; req0_A_i = 32'h12345678; req0_B_i = 32'h0F0F0F0F; req0_op_i = 2'b01;
      req1_valid_i = 1; req1_A_i = 32'hAAAA5555; req1_B_i = 32'hFFFF0000; req1_op_i = 2'b10;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_ready", {req1_ready_o, req0_ready_o}, 2'b00);
         chk("stall_rsp", {rsp_valid_o, rsp_id_o, rsp_result_o}, {1'b1, 1'b0, 32'h00F0F000});
         @(negedge clk);
      end
      rsp_ready_i = 1;
      #1;
      chk("release_ready", {req1_ready_o, req0_ready_o}, 2'b10);
      @(negedge clk);
      req1_valid_i = 0;
      #1;
      chk("release_rsp", {rsp_valid_o, rsp_id_o, rsp_result_o}, {1'b1, 1'b1, 32'hFFFF5555});
      chk("b2b_ready", {req1_ready_o, req0_ready_o}, 2'b01);
      @(negedge clk);
      req0_valid_i = 0;
      #1;
      chk("b2b_rsp", {rsp_valid_o, rsp_id_o, rsp_result_o}, {1'b1, 1'b0, 32'h1D3B5977});

      // Op 11 from requester 1 yields zero but is a normal response
      req1_valid_i = 1; req1_A_i = 32'hFFFFFFFF; req1_B_i = 32'hFFFFFFFF; req1_op_i = 2'b11;
      #1;
      chk("zero_ready", {req1_ready_o, req0_ready_o}, 2'b10);
      @(negedge clk);
      req1_valid_i = 0; rsp_ready_i = 0;
      #1;
      chk("zero_rsp", {rsp_valid_o, rsp_id_o, rsp_result_o}, {1'b1, 1'b1, 32'h00000000});

      // Asynchronous reset mid-cycle while a response is held
      #2;
      rst_i = 1;
      #1;
      chk("arst_rsp", {rsp_valid_o, rsp_id_o, rsp_result_o}, 34'h0);
      @(negedge clk);
      rst_i = 0;
      @(negedge clk); #1;
      chk("arst_stale", rsp_valid_o, 0);
      req0_valid_i = 1; req1_valid_i = 1;
      #1;
      chk("arst_ptr", {req1_ready_o, req0_ready_o}, 2'b01);
      req0_valid_i = 0; req1_valid_i = 0;
      #1;
      rst_i = 1;
      @(negedge clk);
      rst_i = 0;

      // Random valid/ready traffic against a reference model
      m_ptr = 0; pend0 = 0; pend1 = 0; acc0 = 0; acc1 = 0;
      a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
      for (int n = 0; n < 10000; n++) begin
         @(negedge clk);
         if (acc0) pend0 = 0;
         if (acc1) pend1 = 0;
         if (!pend0 && $urandom_range(0, 2) != 0) begin
            pend0 = 1; a0 = $urandom; b0 = $urandom; op0 = 2'($urandom_range(0, 3));
         end
         if (!pend1 && $urandom_range(0, 2) != 0) begin
            pend1 = 1; a1 = $urandom; b1 = $urandom; op1 = 2'($urandom_range(0, 3));
         end
         req0_valid_i = pend0; req0_A_i = a0; req0_B_i = b0; req0_op_i = op0;
         req1_valid_i = pend1; req1_A_i = a1; req1_B_i = b1; req1_op_i = op1;
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         #1;
         m_valid = (exp_q.size() != 0);
         chk("rnd_valid", rsp_valid_o, m_valid);
         m_slot = !m_valid || rsp_ready_i;
         m_g    = (pend0 && pend1) ? m_ptr : pend1;
         acc0   = m_slot && pend0 && !m_g;
         acc1   = m_slot && pend1 && m_g;
         chk("rnd_ready", {req1_ready_o, req0_ready_o}, {acc1, acc0});
         if (m_valid && rsp_ready_i) begin
            exp_rsp = exp_q.pop_front();
            chk("rnd_rsp", {rsp_id_o, rsp_result_o}, exp_rsp);
         end
         if (acc0 || acc1) begin
            exp_q.push_back({m_g, m_g ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0)});
            m_ptr = !m_g;
         end
      end

      @(negedge clk);
      req0_valid_i = 0; req1_valid_i = 0; rsp_ready_i = 1;
      #1;
      if (exp_q.size() != 0) begin
         exp_rsp = exp_q.pop_front();
         chk("rnd_last", {rsp_valid_o, rsp_id_o, rsp_result_o}, {1'b1, exp_rsp});
      end
      @(negedge clk); #1;
      chk("rnd_empty", rsp_valid_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

`default_nettype wire
